pipe_stall_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. Drives the shared `stall[5:0]` vector consumed by the PC register and by every inter-stage register (if_id, id_exe, exe_mem, mem_wb). Each register holds when its own bit is `Stop` and inserts a bubble when its bit is `Stop` and the next bit is `NoStop`. The block arbitrates hazard requests from ID, EXE (multi-cycle MDU), MEM and IF; sequences multi-cycle MDU ops with a counter FSM; and issues exception flushes, deferring them past outstanding data-memory transactions.

---
 rtl/pipe_stall_ctrl.sv | 172 +++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the five-stage pipeline: hazard arbitration, MDU sequencing, deferred exception flush.
// Optional performance counters are enabled by defining CTRL_PERF_EN.
module pipe_stall_ctrl #(
    parameter int MDU_CYCLES = 32,
    parameter int CNT_W      = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic        if_ack,
    input  logic        id_hazard,
    input  logic        exe_mdu_op,
    input  logic        mem_req,
    input  logic        mem_ack,
    input  logic        exc_flush,
    input  logic [31:0] exc_pc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        mdu_done,
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} mdu_state_t;
    typedef enum logic {NORM, PEND} flush_state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_CYCLES - 2);

    logic             mem_wait;
    logic             if_wait;
    logic             mdu_stall;
    logic             mdu_done_c;

    mdu_state_t       mdu_state;
    mdu_state_t       mdu_state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    flush_state_t     fl_state;
    flush_state_t     fl_state_nxt;
    logic [31:0]      pend_pc;
    logic [31:0]      pend_pc_nxt;
    logic             flush_nxt;
    logic [31:0]      new_pc_nxt;

    assign mem_wait = mem_req & ~mem_ack;
    assign if_wait  = if_req & ~if_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            mdu_state <= IDLE;
            cnt       <= '0;
            fl_state  <= NORM;
            pend_pc   <= '0;
            flush     <= 1'b0;
            new_pc    <= '0;
        end else begin
            mdu_state <= mdu_state_nxt;
            cnt       <= cnt_nxt;
            fl_state  <= fl_state_nxt;
            pend_pc   <= pend_pc_nxt;
            flush     <= flush_nxt;
            new_pc    <= new_pc_nxt;
        end
    end

    // MDU sequencer: the MEM stall freezes the countdown, and an active flush kills the op outright.
    always_comb begin
        mdu_state_nxt = mdu_state;
        cnt_nxt       = cnt;
        mdu_stall     = 1'b0;
        mdu_done_c    = 1'b0;
        case (mdu_state)
            IDLE: begin
                if (exe_mdu_op && !flush && !mem_wait) begin
                    mdu_stall     = 1'b1;
                    cnt_nxt       = CNT_LOAD;
                    mdu_state_nxt = RUN;
                end
            end
            RUN: begin
                mdu_stall = 1'b1;
                if (!mem_wait) begin
                    if (cnt == '0) begin
                        mdu_state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt - CNT_W'(1);
                    end
                end
            end
            DONE: begin
                mdu_done_c    = 1'b1;
                mdu_state_nxt = IDLE;
            end
            default: mdu_state_nxt = IDLE;
        endcase
        if (flush) begin
            mdu_state_nxt = IDLE;
            mdu_done_c    = 1'b0;
        end
    end

    // Exceptions wait out an in-flight data access; a newer exception replaces the pending target.
    always_comb begin
        fl_state_nxt = fl_state;
        pend_pc_nxt  = pend_pc;
        flush_nxt    = 1'b0;
        new_pc_nxt   = new_pc;
        case (fl_state)
            NORM: begin
                if (exc_flush) begin
                    if (mem_wait) begin
                        pend_pc_nxt  = exc_pc;
                        fl_state_nxt = PEND;
                    end else begin
                        flush_nxt  = 1'b1;
                        new_pc_nxt = exc_pc;
                    end
                end
            end
            PEND: begin
                if (exc_flush) begin
                    pend_pc_nxt = exc_pc;
                end
                if (!mem_wait) begin
                    flush_nxt    = 1'b1;
                    new_pc_nxt   = exc_flush ? exc_pc : pend_pc;
                    fl_state_nxt = NORM;
                end
            end
            default: fl_state_nxt = NORM;
        endcase
    end

    always_comb begin
        stall = 6'b000000;
        if (reset || flush) begin
            stall = 6'b000000;
        end else if (mem_wait) begin
            stall = 6'b011111;
        end else if (mdu_stall) begin
            stall = 6'b001111;
        end else if (id_hazard) begin
            stall = 6'b000111;
        end else if (if_wait) begin
            stall = 6'b000011;
        end
    end

    assign mdu_done = mdu_done_c & ~reset;

`ifdef CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall != 6'b000000) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_stall_cnt = 32'd0;
    assign perf_flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (MDU_CYCLES=32); perf checks follow CTRL_PERF_EN.
module tb_pipe_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_ack, id_hazard, exe_mdu_op, mem_req, mem_ack, exc_flush;
    logic [31:0] exc_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        mdu_done;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    pipe_stall_ctrl #(.MDU_CYCLES(32), .CNT_W(6)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_ack(if_ack), .id_hazard(id_hazard), .exe_mdu_op(exe_mdu_op),
        .mem_req(mem_req), .mem_ack(mem_ack), .exc_flush(exc_flush), .exc_pc(exc_pc),
        .stall(stall), .flush(flush), .new_pc(new_pc), .mdu_done(mdu_done),
        .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the clock edge; outputs are sampled 2ns later.
    task automatic applyStimulus(input logic ifr, input logic ifa, input logic idh, input logic mdu,
                                 input logic mr, input logic ma, input logic exf, input logic [31:0] pc);
        if_req = ifr; if_ack = ifa; id_hazard = idh; exe_mdu_op = mdu;
        mem_req = mr; mem_ack = ma; exc_flush = exf; exc_pc = pc;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 32'h0);
    endtask

    task automatic doReset();
        reset = 1'b1;
        idle();
        step(); step();
        reset = 1'b0;
    endtask

    int bad;
    logic [5:0] exp_stall;

    initial begin
        reset = 1'b1;
        idle();
        #1;
        doReset();
        idle();
        checkOutput("reset_stall", 32'(stall), 32'h0);
        checkOutput("reset_flush", 32'(flush), 32'h0);
        checkOutput("reset_new_pc", new_pc, 32'h0);
        checkOutput("reset_mdu_done", 32'(mdu_done), 32'h0);
        checkOutput("reset_perf_stall", perf_stall_cnt, 32'h0);
        checkOutput("reset_perf_flush", perf_flush_cnt, 32'h0);

        step(); applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
        checkOutput("id_hazard_stall", 32'(stall), 32'h07);
        step(); idle();
        checkOutput("id_hazard_release", 32'(stall), 32'h00);

        step(); applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("if_wait_stall", 32'(stall), 32'h03);
        step(); applyStimulus(1, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("if_ack_release", 32'(stall), 32'h00);

        for (int i = 0; i < 3; i++) begin
            step(); applyStimulus(0, 0, 1, 0, 1, 0, 0, 0);
            checkOutput($sformatf("mem_wait_stall_%0d", i), 32'(stall), 32'h1F);
        end
        step(); applyStimulus(0, 0, 1, 0, 1, 1, 0, 0);
        checkOutput("mem_ack_to_hazard", 32'(stall), 32'h07);
        step(); applyStimulus(0, 0, 0, 0, 1, 1, 0, 0);
        checkOutput("mem_same_cycle_ack", 32'(stall), 32'h00);

        for (int k = 0; k < 32; k++) begin
            step(); applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
            checkOutput($sformatf("mdu_stall_%0d", k), 32'(stall), 32'h0F);
            checkOutput($sformatf("mdu_done_low_%0d", k), 32'(mdu_done), 32'h0);
        end
        step(); applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        checkOutput("mdu_done_pulse", 32'(mdu_done), 32'h1);
        checkOutput("mdu_done_no_restart", 32'(stall), 32'h00);
        step(); idle();
        checkOutput("mdu_after_done", 32'(mdu_done), 32'h0);
        checkOutput("mdu_after_done_stall", 32'(stall), 32'h00);

        for (int k = 0; k < 36; k++) begin
            step();
            if (k >= 5 && k <= 7) applyStimulus(0, 0, 0, 1, 1, 0, 0, 0);
            else                  applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
            exp_stall = (k >= 5 && k <= 7) ? 6'h1F : (k < 35 ? 6'h0F : 6'h00);
            checkOutput($sformatf("mdu_freeze_stall_%0d", k), 32'(stall), 32'(exp_stall));
            checkOutput($sformatf("mdu_freeze_done_%0d", k), 32'(mdu_done), (k == 35) ? 32'h1 : 32'h0);
        end
        step(); idle();

        step(); applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'hBFC00380);
        checkOutput("defer_wait0_stall", 32'(stall), 32'h1F);
        checkOutput("defer_wait0_flush", 32'(flush), 32'h0);
        step(); applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
        checkOutput("defer_wait1_flush", 32'(flush), 32'h0);
        step(); applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h0);
        checkOutput("defer_wait2_flush", 32'(flush), 32'h0);
        step(); applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'h0);
        checkOutput("defer_ack_flush", 32'(flush), 32'h0);
        step(); idle();
        checkOutput("defer_flush", 32'(flush), 32'h1);
        checkOutput("defer_new_pc", new_pc, 32'hBFC00380);
        checkOutput("defer_flush_stall", 32'(stall), 32'h00);
        step(); idle();
        checkOutput("defer_flush_single", 32'(flush), 32'h0);

        step(); applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h80000180);
        checkOutput("imm_exc_cycle", 32'(flush), 32'h0);
        step(); applyStimulus(0, 0, 1, 0, 0, 0, 1, 32'h11110000);
        checkOutput("imm_flush", 32'(flush), 32'h1);
        checkOutput("imm_new_pc", new_pc, 32'h80000180);
        checkOutput("flush_beats_hazard", 32'(stall), 32'h00);
        step(); idle();
        checkOutput("b2b_flush", 32'(flush), 32'h1);
        checkOutput("b2b_new_pc", new_pc, 32'h11110000);
        step(); idle();
        checkOutput("b2b_flush_end", 32'(flush), 32'h0);

        step(); applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'hAAAA0000);
        step(); applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'hBBBB0000);
        checkOutput("overwrite_wait_flush", 32'(flush), 32'h0);
        step(); applyStimulus(0, 0, 0, 0, 1, 1, 0, 32'h0);
        step(); idle();
        checkOutput("overwrite_flush", 32'(flush), 32'h1);
        checkOutput("overwrite_new_pc", new_pc, 32'hBBBB0000);

        for (int k = 0; k <= 21; k++) begin
            step();
            applyStimulus(0, 0, 0, 1, 0, 0, (k == 21), 32'h80000080);
        end
        checkOutput("mdu_kill_pre_stall", 32'(stall), 32'h0F);
        step(); applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("mdu_kill_flush", 32'(flush), 32'h1);
        checkOutput("mdu_kill_stall", 32'(stall), 32'h00);
        checkOutput("mdu_kill_new_pc", new_pc, 32'h80000080);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            step(); idle();
            if (mdu_done !== 1'b0 || stall !== 6'h00) bad++;
        end
        checkOutput("mdu_kill_quiet", 32'(bad), 32'h0);

        step(); applyStimulus(0, 0, 0, 0, 1, 0, 1, 32'hCCCC0000);
        step();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        idle();
        checkOutput("reset_pend_flush", 32'(flush), 32'h0);
        step(); idle();
        checkOutput("reset_pend_flush_later", 32'(flush), 32'h0);

        for (int k = 0; k < 5; k++) begin
            step(); applyStimulus(0, 0, 0, 1, 0, 0, 0, 0);
        end
        step();
        reset = 1'b1;
        idle();
        step();
        reset = 1'b0;
        bad = 0;
        for (int k = 0; k < 36; k++) begin
            idle();
            if (mdu_done !== 1'b0 || stall !== 6'h00) bad++;
            step();
        end
        checkOutput("reset_mdu_quiet", 32'(bad), 32'h0);

        doReset();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 0, 1, 0, 0, 0, 0, 0);
            step();
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h1);
        step(); idle(); step();
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h2);
        step(); idle(); step();
        idle();
`ifdef CTRL_PERF_EN
        checkOutput("perf_stall_count", perf_stall_cnt, 32'd5);
        checkOutput("perf_flush_count", perf_flush_cnt, 32'd2);
`else
        checkOutput("perf_stall_tied", perf_stall_cnt, 32'd0);
        checkOutput("perf_flush_tied", perf_flush_cnt, 32'd0);
`endif
        doReset();
        idle();
        checkOutput("perf_stall_cleared", perf_stall_cnt, 32'd0);
        checkOutput("perf_flush_cleared", perf_flush_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
